// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the master CPU sequencer.
//   - state_t      : sequencer FSM state encoding
//   - OP_*         : opcodes the sequencer treats specially (all others are ALU ops)
//   - COND_*       : ARM-style condition codes
//   - FLAG_*       : bit positions of N, Z, C, V inside the 4-bit flags word
package cpu_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LATCH    = 3'd2,
        S_DECODE   = 3'd3,
        S_EXEC     = 3'd4,
        S_MEM_WAIT = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [3:0] OP_LDR  = 4'hA;
    localparam logic [3:0] OP_STR  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/cpu_sequencer_cond_eval.sv
// cpu_sequencer_cond_eval: combinational ARM condition-code evaluator.
// Ports:
//   i_cond  [3:0] : condition field of the instruction
//   i_flags [3:0] : flags word {N,Z,C,V}
//   o_pass        : 1 when the instruction should execute
module cpu_sequencer_cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_pass
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLAG_N];
    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_pass = 1'b0;
        case (i_cond)
            COND_EQ: o_pass = w_z;
            COND_NE: o_pass = !w_z;
            COND_CS: o_pass = w_c;
            COND_CC: o_pass = !w_c;
            COND_MI: o_pass = w_n;
            COND_PL: o_pass = !w_n;
            COND_VS: o_pass = w_v;
            COND_VC: o_pass = !w_v;
            COND_HI: o_pass = w_c && !w_z;
            COND_LS: o_pass = !w_c || w_z;
            COND_GE: o_pass = (w_n == w_v);
            COND_LT: o_pass = (w_n != w_v);
            COND_GT: o_pass = !w_z && (w_n == w_v);
            COND_LE: o_pass = w_z || (w_n != w_v);
            COND_AL: o_pass = 1'b1;
            COND_NV: o_pass = 1'b0;
            default: o_pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller. Owns the PC and
// the architectural flags, shares the single RAM port between instruction
// fetch and LDR/STR data access, and strobes register-bank writes.
// Ports:
//   Clk, Reset (sync, active high), Run (level, allows leaving IDLE)
//   ram_en/ram_rw/ram_addr/ram_wdata : RAM request (ram_rw 1 = read)
//   ram_rdata                        : RAM read data, valid the cycle after a read request
//   instr                            : latched instruction word
//   rf_rdata1/rf_rdata2              : register bank reads of src1/src2
//   rf_we/rf_wdata                   : one-cycle register write strobe and data
//   alu_result/alu_new_flag          : ALU result and its {N,Z,C,V}
//   flags, pc, halted                : architectural state
//   dbg_state                        : current FSM state (state_t encoding)
// Handshake: there is none; every RAM request is a single-cycle strobe and
// read data is consumed exactly one cycle after its request.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_new_flag,
    output logic [3:0]        flags,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic [2:0]        dbg_state
);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_instr;
    logic [3:0]          r_flags;

    state_t              w_state_nxt;
    logic [PC_W-1:0]     w_pc_nxt;
    logic [DATA_W-1:0]   w_instr_nxt;
    logic [3:0]          w_flags_nxt;
    logic                w_pass;
    logic [3:0]          w_opcode;
    logic                w_s_bit;
    logic [PC_W-1:0]     w_pc_inc;
    state_t              w_after;
    logic                w_unused_ok;

    assign w_opcode = r_instr[27:24];
    assign w_s_bit  = r_instr[23];
    assign w_pc_inc = r_pc + PC_W'(1);
    // Stop at the fetch boundary once Run has been dropped.
    assign w_after  = Run ? S_FETCH : S_IDLE;
    // Only the low address bits of src1 are used as a data address.
    assign w_unused_ok = &{1'b0, rf_rdata1[DATA_W-1:ADDR_W]};

    cpu_sequencer_cond_eval u_cond_eval (
        .i_cond  (r_instr[31:28]),
        .i_flags (r_flags),
        .o_pass  (w_pass)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_flags <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_flags_nxt = r_flags;
        ram_en      = 1'b0;
        ram_rw      = 1'b1;
        ram_addr    = '0;
        ram_wdata   = '0;
        rf_we       = 1'b0;
        rf_wdata    = '0;

        case (r_state)
            S_IDLE: begin
                if (Run) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ram_en      = 1'b1;
                ram_addr    = {{(ADDR_W-PC_W){1'b0}}, r_pc};
                w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                w_instr_nxt = ram_rdata;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if (w_pass) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = w_after;
                end
            end
            S_EXEC: begin
                case (w_opcode)
                    OP_LDR: begin
                        ram_en      = 1'b1;
                        ram_addr    = rf_rdata1[ADDR_W-1:0];
                        w_state_nxt = S_MEM_WAIT;
                    end
                    OP_STR: begin
                        ram_en      = 1'b1;
                        ram_rw      = 1'b0;
                        ram_addr    = rf_rdata1[ADDR_W-1:0];
                        ram_wdata   = rf_rdata2;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = w_after;
                    end
                    OP_B: begin
                        // Branch target is the low PC bits of IV_Mov (instr[18:3]).
                        w_pc_nxt    = r_instr[3 +: PC_W];
                        w_state_nxt = w_after;
                    end
                    OP_HALT: begin
                        w_state_nxt = S_HALT;
                    end
                    default: begin
                        rf_we    = 1'b1;
                        rf_wdata = alu_result;
                        if (w_s_bit) w_flags_nxt = alu_new_flag;
                        w_pc_nxt    = w_pc_inc;
                        w_state_nxt = w_after;
                    end
                endcase
            end
            S_MEM_WAIT: begin
                rf_we       = 1'b1;
                rf_wdata    = ram_rdata;
                w_pc_nxt    = w_pc_inc;
                w_state_nxt = w_after;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Reset suppresses every strobe in the same cycle, even mid-instruction.
        if (Reset) begin
            ram_en    = 1'b0;
            ram_rw    = 1'b1;
            ram_addr  = '0;
            ram_wdata = '0;
            rf_we     = 1'b0;
            rf_wdata  = '0;
        end
    end

    assign instr     = r_instr;
    assign flags     = r_flags;
    assign pc        = r_pc;
    assign halted    = (r_state == S_HALT);
    assign dbg_state = r_state;

endmodule
